// File: rtl/add_share_arb.sv
// Round-robin arbiter sharing one external combinational adder between two
// requesters, each with a private accumulator; results return on one tagged response port.
module add_share_arb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_acc,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_acc,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_sum,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_id
);

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_0,
    GNT_1
  } grant_e;

  grant_e           grant;
  logic             slot_free;

  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_sum_q,   rsp_sum_d;
  logic             rsp_id_q,    rsp_id_d;
  logic [WIDTH-1:0] acc0_q,      acc0_d;
  logic [WIDTH-1:0] acc1_q,      acc1_d;
  logic             last_grant_q, last_grant_d;

  // Grant depends only on valids, rsp_ready and state, never on add_sum.
  always_comb begin
    slot_free = !rsp_valid_q || rsp_ready;
    grant     = GNT_NONE;
    if (slot_free) begin
      if (req0_valid && req1_valid) begin
        grant = last_grant_q ? GNT_0 : GNT_1;
      end else if (req0_valid) begin
        grant = GNT_0;
      end else if (req1_valid) begin
        grant = GNT_1;
      end
    end
  end

  assign req0_ready = (grant == GNT_0);
  assign req1_ready = (grant == GNT_1);

  always_comb begin
    add_a        = '0;
    add_b        = '0;
    rsp_valid_d  = rsp_valid_q;
    rsp_sum_d    = rsp_sum_q;
    rsp_id_d     = rsp_id_q;
    acc0_d       = acc0_q;
    acc1_d       = acc1_q;
    last_grant_d = last_grant_q;

    case (grant)
      GNT_0: begin
        add_a        = req0_acc ? acc0_q : req0_a;
        add_b        = req0_b;
        rsp_valid_d  = 1'b1;
        rsp_sum_d    = add_sum;
        rsp_id_d     = 1'b0;
        acc0_d       = add_sum;
        last_grant_d = 1'b0;
      end
      GNT_1: begin
        add_a        = req1_acc ? acc1_q : req1_a;
        add_b        = req1_b;
        rsp_valid_d  = 1'b1;
        rsp_sum_d    = add_sum;
        rsp_id_d     = 1'b1;
        acc1_d       = add_sum;
        last_grant_d = 1'b1;
      end
      default: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_sum_q    <= '0;
      rsp_id_q     <= 1'b0;
      acc0_q       <= '0;
      acc1_q       <= '0;
      last_grant_q <= 1'b1;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_sum_q    <= rsp_sum_d;
      rsp_id_q     <= rsp_id_d;
      acc0_q       <= acc0_d;
      acc1_q       <= acc1_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: doc/add_share_arb.md
# add_share_arb

Round-robin arbiter and sequencer that shares one external combinational WIDTH-bit adder between two requesters. Each requester has a valid/ready handshake and a private accumulator. Results come back through a single registered response port tagged with the requester id. The block sits between the top-level pin logic and the shared adder, so a second adder instance is never needed.

## Interface
- WIDTH, 8, operand/result width; sums wrap modulo 2^WIDTH
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  requester N has an operation pending
- req0_ready / req1_ready  out  1  requester N's operation is accepted this cycle
- req0_a / req1_a  in  WIDTH  operand A
- req0_b / req1_b  in  WIDTH  operand B
- req0_acc / req1_acc  in  1  1 = use requester N's accumulator in place of operand A
- add_a  out  WIDTH  operand A driven to the shared adder
- add_b  out  WIDTH  operand B driven to the shared adder
- add_sum  in  WIDTH  adder result, combinational from add_a/add_b in the same cycle
- rsp_valid  out  1  response register holds a result
- rsp_ready  in  1  consumer takes the response this cycle
- rsp_sum  out  WIDTH  registered sum
- rsp_id  out  1  requester that produced rsp_sum

## Operation
- State: response register (rsp_valid, rsp_sum, rsp_id); acc0, acc1 (WIDTH each); last_grant (1 bit).
- slot_free = !rsp_valid | rsp_ready.
- Arbitration, combinational, only when slot_free:
  - Exactly one requester valid: that requester is granted.
  - Both valid: the requester other than last_grant is granted.
  - No requester valid, or slot not free: no grant.
- reqN_ready = grant to N. At most one ready per cycle. reqN_ready may depend on reqN_valid, the other requester's valid and rsp_ready.
- Operand mux on grant to N:
  - add_a = reqN_acc ? accN : reqN_a
  - add_b = reqN_b
- With no grant, add_a = add_b = 0.
- On a clock edge with grant to N:
  - rsp_sum <= add_sum
  - rsp_id <= N
  - rsp_valid <= 1
  - accN <= add_sum
  - last_grant <= N
  - The other accumulator is unchanged.
- On a clock edge with no grant, when rsp_valid & rsp_ready: rsp_valid <= 0. rsp_sum and rsp_id hold their last values.
- With rsp_valid & !rsp_ready, the response is frozen and no grant occurs. Requesters hold their operands (standard valid/ready rules).
- Arithmetic: WIDTH bits, carry discarded. 0xFF + 0x01 = 0x00 at WIDTH=8.
- Reset (async assert, synchronous release) gives:
  - rsp_valid = 0, rsp_sum = 0, rsp_id = 0
  - acc0 = acc1 = 0
  - last_grant = 1, so requester 0 wins the first contention
  - With no requesters valid, all ready outputs and add_a/add_b are 0 in reset.
- Reset mid-operation: a pending or unconsumed response is discarded and the accumulators are cleared. No response is produced for any operation accepted before reset.

## Timing
- Latency: an operation accepted on edge k is visible at rsp_* after edge k.
- Throughput: one operation per cycle while rsp_ready = 1. Back-to-back consume and accept in the same cycle is required (no bubble).
- Accumulate chain: requester N's acc operation accepted on edge k+1 sees the accN written at edge k.
- No combinational path from add_sum to any ready or valid output.

## Test plan
- Reset, then req0 alone with a=0x12, b=0x34, acc=0, rsp_ready=1 -> req0_ready=1 in that cycle. Next cycle rsp_valid=1, rsp_sum=0x46, rsp_id=0.
- Both valid every cycle, rsp_ready=1, starting right after reset -> grants alternate 0,1,0,1 and rsp_id alternates identically. No bubble cycles.
- req1 with acc=1, b=0x01, held valid for 3 cycles -> rsp_sum sequence 0x01, 0x02, 0x03. acc0 stays 0.
- Wrap: req0 a=0xFF, b=0x01 -> rsp_sum=0x00. Then acc=1, b=0x05 -> rsp_sum=0x05.
- Backpressure: rsp_ready=0 for 4 cycles with both valid -> both readys stay 0 and rsp_* is unchanged. When rsp_ready rises, a grant occurs in that same cycle and the new result appears next cycle.
- Assert rst_n low while rsp_valid=1 and acc0=0x20 -> rsp_valid=0 immediately (async). After release, req0 acc=1, b=0x03 -> rsp_sum=0x03.
